// File: rtl/alu_wb_buffer.sv
// Registered in-order result buffer between the integer ALU and the writeback/scoreboard port.
// Latency: a result captured in cycle N is presented on the wb side in cycle N+1 at the earliest.
// Backpressure: alu_ready_o drops only when full and the head is not being popped this cycle.
module alu_wb_buffer #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       alu_valid_i,
  output logic                       alu_ready_o,
  input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
  input  logic [XLEN-1:0]            result_i,
  input  logic                       branch_res_i,
  input  logic                       tb_sext_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [XLEN-1:0]            wb_result_o,
  output logic                       wb_branch_res_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // One buffered ALU result.
  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    logic                     branch_res;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic               push;
  logic               pop;
  entry_t             wr_entry;

  // Handshake decode: a flush cycle cancels both the capture and the retire.
  always_comb begin
    alu_ready_o = (count < CNT_W'(DEPTH)) | wb_ready_i;
    wb_valid_o  = (count != '0);
    push        = alu_valid_i & alu_ready_o & ~flush_i;
    pop         = wb_valid_o & wb_ready_i & ~flush_i;
  end

  // Build the entry to store; turbo-decoder ops produce an 8-bit signed result.
  always_comb begin
    wr_entry.trans_id   = trans_id_i;
    wr_entry.branch_res = branch_res_i;
    if (tb_sext_i) begin
      wr_entry.result = {{(XLEN-8){result_i[7]}}, result_i[7:0]};
    end else begin
      wr_entry.result = result_i;
    end
  end

  // Entry storage is deliberately not reset; only valid entries are ever observed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointer and occupancy control; flush collapses the queue onto the write pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry drives the writeback port straight from the register array.
  always_comb begin
    wb_trans_id_o   = mem[rd_ptr].trans_id;
    wb_result_o     = mem[rd_ptr].result;
    wb_branch_res_o = mem[rd_ptr].branch_res;
    count_o         = count;
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed self-checking bench for alu_wb_buffer.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// All expected values are hand-computed constants.
module tb_alu_wb_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  trans_id;
  logic [63:0] result;
  logic        branch_res;
  logic        tb_sext;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_trans_id;
  logic [63:0] wb_result;
  logic        wb_branch_res;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  alu_wb_buffer #(.XLEN(64), .TRANS_ID_BITS(3), .DEPTH(2)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .alu_valid_i     (alu_valid),
    .alu_ready_o     (alu_ready),
    .trans_id_i      (trans_id),
    .result_i        (result),
    .branch_res_i    (branch_res),
    .tb_sext_i       (tb_sext),
    .wb_valid_o      (wb_valid),
    .wb_ready_i      (wb_ready),
    .wb_trans_id_o   (wb_trans_id),
    .wb_result_o     (wb_result),
    .wb_branch_res_o (wb_branch_res),
    .count_o         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one result for a single cycle, then drop valid.
  task automatic push_one(input logic [2:0] id, input logic [63:0] res,
                          input logic br, input logic sx);
    alu_valid  = 1'b1;
    trans_id   = id;
    result     = res;
    branch_res = br;
    tb_sext    = sx;
    step();
    alu_valid  = 1'b0;
    tb_sext    = 1'b0;
  endtask

  logic [63:0] sx_in  [4];
  logic        sx_en  [4];
  logic [63:0] sx_exp [4];

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; alu_valid = 1'b0; trans_id = '0;
    result = '0; branch_res = 1'b0; tb_sext = 1'b0; wb_ready = 1'b0;

    sx_in[0] = 64'h00000000000000A0; sx_en[0] = 1'b1; sx_exp[0] = 64'hFFFFFFFFFFFFFFA0;
    sx_in[1] = 64'hFFFFFFFFFFFFFF35; sx_en[1] = 1'b1; sx_exp[1] = 64'h0000000000000035;
    sx_in[2] = 64'h00000000000000A0; sx_en[2] = 1'b0; sx_exp[2] = 64'h00000000000000A0;
    sx_in[3] = 64'hFFFFFFFFFFFFFF35; sx_en[3] = 1'b0; sx_exp[3] = 64'hFFFFFFFFFFFFFF35;

    // Reset state
    #2;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_count", count, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_alu_ready", alu_ready, 1);

    // Single transfer
    wb_ready = 1'b1;
    push_one(3'd3, 64'h1234, 1'b1, 1'b0);
    chk("single_valid", wb_valid, 1);
    chk("single_id", wb_trans_id, 3);
    chk("single_result", wb_result, 64'h1234);
    chk("single_branch", wb_branch_res, 1);
    chk("single_count", count, 1);
    step();
    chk("single_drain_valid", wb_valid, 0);
    chk("single_drain_count", count, 0);

    // Sign extension table
    for (int i = 0; i < 4; i++) begin
      push_one(3'(i), sx_in[i], 1'b0, sx_en[i]);
      chk($sformatf("sext_result_%0d", i), wb_result, sx_exp[i]);
      step();
      chk($sformatf("sext_drain_%0d", i), count, 0);
    end

    // Backpressure / full with a held third result
    wb_ready = 1'b0;
    push_one(3'd1, 64'h11, 1'b0, 1'b0);
    push_one(3'd2, 64'h22, 1'b1, 1'b0);
    chk("full_count", count, 2);
    chk("full_ready", alu_ready, 0);
    alu_valid = 1'b1; trans_id = 3'd4; result = 64'h44; branch_res = 1'b0;
    step();
    chk("held_count", count, 2);
    chk("held_head", wb_trans_id, 1);
    wb_ready = 1'b1;
    #1;
    chk("full_pop_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    chk("bp_head_2", wb_trans_id, 2);
    chk("bp_head_2_res", wb_result, 64'h22);
    chk("bp_count_2", count, 2);
    step();
    chk("bp_head_4", wb_trans_id, 4);
    chk("bp_head_4_res", wb_result, 64'h44);
    chk("bp_count_1", count, 1);
    step();
    chk("bp_empty", wb_valid, 0);
    chk("bp_count_0", count, 0);

    // Push and pop at full
    wb_ready = 1'b0;
    push_one(3'd1, 64'h51, 1'b0, 1'b0);
    push_one(3'd3, 64'h53, 1'b0, 1'b0);
    wb_ready = 1'b1;
    push_one(3'd5, 64'h55, 1'b1, 1'b0);
    chk("pp_count", count, 2);
    chk("pp_head_3", wb_trans_id, 3);
    step();
    chk("pp_head_5", wb_trans_id, 5);
    chk("pp_head_5_branch", wb_branch_res, 1);
    chk("pp_count_1", count, 1);
    step();
    chk("pp_count_0", count, 0);

    // Flush with simultaneous push and pop attempt
    wb_ready = 1'b0;
    push_one(3'd6, 64'h66, 1'b0, 1'b0);
    push_one(3'd7, 64'h77, 1'b0, 1'b0);
    chk("fl_pre_count", count, 2);
    flush = 1'b1; wb_ready = 1'b1;
    push_one(3'd0, 64'h00, 1'b0, 1'b0);
    flush = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_valid", wb_valid, 0);
    push_one(3'd2, 64'h2222, 1'b0, 1'b0);
    chk("fl_next_id", wb_trans_id, 2);
    chk("fl_next_res", wb_result, 64'h2222);
    chk("fl_next_count", count, 1);
    step();
    chk("fl_drain_valid", wb_valid, 0);
    chk("fl_drain_count", count, 0);

    // Asynchronous reset mid-cycle with two entries buffered
    wb_ready = 1'b0;
    push_one(3'd1, 64'h1, 1'b0, 1'b0);
    push_one(3'd2, 64'h2, 1'b0, 1'b0);
    chk("ar_pre_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", wb_valid, 0);
    chk("ar_count", count, 0);
    #1;
    rst_n = 1'b1;
    step();
    chk("ar_ready", alu_ready, 1);
    wb_ready = 1'b1;
    push_one(3'd5, 64'hABCD, 1'b1, 1'b0);
    chk("ar_next_id", wb_trans_id, 5);
    chk("ar_next_res", wb_result, 64'hABCD);
    step();
    chk("ar_drain_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
- Registered result stage directly downstream of the integer ALU. Captures each ALU result together with its scoreboard transaction ID and branch flag.
- Sign-extends the 8-bit results of turbo-decoder ops (TB_MAX, TB_SCALE) to XLEN.
- Holds results in a small in-order FIFO so the writeback/scoreboard port can apply backpressure without stalling issue combinationally.
- Decouples the ALU's combinational output from the writeback arbitration timing path.

Parameters:
- XLEN, 64, datapath width of result.
- TRANS_ID_BITS, 3, width of the scoreboard transaction ID.
- DEPTH, 2, number of FIFO entries; must be a power of two, >= 2.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- flush_i  input  1  pipeline flush; discards all buffered and incoming entries.
- alu_valid_i  input  1  ALU result valid this cycle.
- alu_ready_o  output  1  buffer can accept an entry this cycle.
- trans_id_i  input  TRANS_ID_BITS  scoreboard ID of the incoming result.
- result_i  input  XLEN  ALU result.
- branch_res_i  input  1  ALU branch-compare result.
- tb_sext_i  input  1  incoming op is TB_MAX/TB_SCALE; sign-extend result_i[7:0].
- wb_valid_o  output  1  head entry valid.
- wb_ready_i  input  1  writeback accepts the head entry.
- wb_trans_id_o  output  TRANS_ID_BITS  head entry ID.
- wb_result_o  output  XLEN  head entry result.
- wb_branch_res_o  output  1  head entry branch flag.
- count_o  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH entries of {trans_id, result, branch_res}, plus read pointer, write pointer and occupancy counter.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- Reset (rst_ni low, asynchronous): pointers = 0, count = 0, wb_valid_o = 0. alu_ready_o = 1 as soon as reset deasserts.
  - Entry contents are not reset.
  - wb_trans_id_o, wb_result_o and wb_branch_res_o read entry 0, are don't-care while wb_valid_o = 0, and must never be X-dependent for valid/ready.
- Push when alu_valid_i & alu_ready_o & ~flush_i.
  - Stored result = tb_sext_i ? {{XLEN-8{result_i[7]}}, result_i[7:0]} : result_i.
- Pop when wb_valid_o & wb_ready_i & ~flush_i.
- Output signals:
  - alu_ready_o = (count < DEPTH) | wb_ready_i, so a push is allowed at full when the head pops the same cycle.
  - wb_valid_o = (count != 0). Outputs are driven directly from the head entry register.
- Latency: a push in cycle N appears on wb_valid_o in cycle N+1 at the earliest. There is no combinational path from alu_valid_i to wb_valid_o.
- Ordering: strict FIFO; entries are never reordered or dropped except by flush.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - At count = 1, the new entry becomes head in the next cycle.
  - At count = DEPTH, the push is accepted.
- Full (count = DEPTH) with wb_ready_i = 0: alu_ready_o = 0. The ALU holds its result. An alu_valid_i asserted without ready is not captured.
- Empty: wb_valid_o = 0. wb_ready_i is ignored; no underflow and no pointer movement.
- Flush: registered effect. In the cycle after flush_i is high, count = 0, rd_ptr = wr_ptr, and wb_valid_o = 0.
  - Any push or pop in the flush cycle is discarded.
  - alu_ready_o may remain asserted during flush.
- Reset mid-operation: all buffered entries are lost and outputs return to reset values immediately (asynchronous).
- count_o equals the number of valid entries at all times and never exceeds DEPTH.

Test Plan:
- Single transfer: after reset, push id=3, result=0x1234, branch=1, wb_ready_i=1 → next cycle wb_valid_o=1, wb_trans_id_o=3, wb_result_o=0x1234, wb_branch_res_o=1; cycle after that wb_valid_o=0, count_o=0.
- TB sign extension: push result_i=0x00000000000000A0, tb_sext_i=1 → wb_result_o=0xFFFFFFFFFFFFFFA0. Push 0xFFFFFFFFFFFFFF35, tb_sext_i=1 → 0x0000000000000035. Same values with tb_sext_i=0 → unchanged.
- Backpressure/full: wb_ready_i=0, push ids 1,2 → count_o=2, alu_ready_o=0. A third valid id=4 is held without capture. Raise wb_ready_i → outputs 1,2,4 in order, no loss or duplication.
- Push+pop at full: count=2, wb_ready_i=1, alu_valid_i=1 id=5 → count stays 2, head advances, id=5 appears after the older entry.
- Flush: ids 6,7 buffered, flush_i=1 for one cycle with a simultaneous push of id=0 → next cycle count_o=0, wb_valid_o=0. A subsequent push of id=2 is output next and nothing stale appears.
- Async reset: assert rst_ni=0 between clock edges with count=2 → wb_valid_o=0 and count_o=0 immediately. After release, alu_ready_o=1 and the next push passes through normally.
